// File: rtl/fft_pkg.sv
// Shared widths, complex sample types and sign-extension helper for the FFT datapath.
package fft_pkg;

    localparam int unsigned FFT_IN_WIDTH   = 13;
    localparam int unsigned FFT_OUT_WIDTH  = 14;
    localparam int unsigned FFT_LANES      = 16;
    localparam int unsigned FFT_BFLY_DEPTH = 4;

    typedef struct packed {
        logic signed [FFT_IN_WIDTH-1:0] re;
        logic signed [FFT_IN_WIDTH-1:0] im;
    } cplx13_t;

    typedef struct packed {
        logic signed [FFT_OUT_WIDTH-1:0] re;
        logic signed [FFT_OUT_WIDTH-1:0] im;
    } cplx14_t;

    // Output width is exactly one bit wider, so replicating the sign bit once is exact.
    function automatic logic signed [FFT_OUT_WIDTH-1:0] sext13to14(
        input logic signed [FFT_IN_WIDTH-1:0] x
    );
        return {x[FFT_IN_WIDTH-1], x};
    endfunction

endpackage

// File: rtl/fft_bfly2_lane.sv
// One lane of the radix-2 butterfly: exact complex (a+b, a-b) with one bit of growth.
module fft_bfly2_lane
    import fft_pkg::*;
(
    input  cplx13_t a,
    input  cplx13_t b,
    output cplx14_t sum,
    output cplx14_t diff
);

    always_comb begin
        sum.re  = sext13to14(a.re) + sext13to14(b.re);
        sum.im  = sext13to14(a.im) + sext13to14(b.im);
        diff.re = sext13to14(a.re) - sext13to14(b.re);
        diff.im = sext13to14(a.im) - sext13to14(b.im);
    end

endmodule

// File: rtl/fft_step1_bfly_buf.sv
// Step1 radix-2 butterfly: pairs beat k with beat k+DEPTH, emits the frame's sums then
// drains the buffered differences back-to-back.
module fft_step1_bfly_buf
    import fft_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = FFT_IN_WIDTH,
    parameter int unsigned OUT_WIDTH = FFT_OUT_WIDTH,
    parameter int unsigned LANES     = FFT_LANES,
    parameter int unsigned DEPTH     = FFT_BFLY_DEPTH
)(
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         din_valid,
    input  logic [IN_WIDTH*LANES-1:0]    din_real,
    input  logic [IN_WIDTH*LANES-1:0]    din_imag,
    output logic                         valid_out,
    output logic                         dout_sel,
    output logic [OUT_WIDTH*LANES-1:0]   dout_real,
    output logic [OUT_WIDTH*LANES-1:0]   dout_imag
);

    localparam int unsigned CNT_W  = $clog2(2 * DEPTH);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned PEND_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  cnt;
    logic [PEND_W-1:0] pend;
    logic [PTR_W-1:0]  dptr;

    cplx13_t [LANES-1:0] abuf [DEPTH];
    cplx14_t [LANES-1:0] dbuf [DEPTH];
    cplx14_t [LANES-1:0] dout_q;

    cplx13_t [LANES-1:0] din_c;
    cplx13_t [LANES-1:0] a_c;
    cplx14_t [LANES-1:0] sum_c;
    cplx14_t [LANES-1:0] diff_c;

    logic             phase_b_c;
    logic             take_b_c;
    logic             drain_c;
    logic [PTR_W-1:0] bidx_c;

    // DEPTH is a power of two, so the low cnt bits give the slot in both phases.
    always_comb begin
        phase_b_c = (cnt >= CNT_W'(DEPTH));
        take_b_c  = din_valid && phase_b_c;
        drain_c   = !phase_b_c && (pend != '0);
        bidx_c    = cnt[PTR_W-1:0];
        a_c       = abuf[bidx_c];
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign din_c[i].re = din_real[i*IN_WIDTH +: IN_WIDTH];
        assign din_c[i].im = din_imag[i*IN_WIDTH +: IN_WIDTH];

        fft_bfly2_lane u_lane (
            .a    (a_c[i]),
            .b    (din_c[i]),
            .sum  (sum_c[i]),
            .diff (diff_c[i])
        );

        assign dout_real[i*OUT_WIDTH +: OUT_WIDTH] = dout_q[i].re;
        assign dout_imag[i*OUT_WIDTH +: OUT_WIDTH] = dout_q[i].im;
    end

    // Control and output register; sums and the drain are mutually exclusive by cnt phase.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            pend      <= '0;
            dptr      <= '0;
            valid_out <= 1'b0;
            dout_sel  <= 1'b0;
            dout_q    <= '0;
        end else begin
            valid_out <= 1'b0;
            if (din_valid) begin
                cnt <= (cnt == CNT_W'(2 * DEPTH - 1)) ? '0 : cnt + CNT_W'(1);
            end
            if (take_b_c) begin
                dout_q    <= sum_c;
                dout_sel  <= 1'b0;
                valid_out <= 1'b1;
                pend      <= pend + PEND_W'(1);
            end else if (drain_c) begin
                dout_q    <= dbuf[dptr];
                dout_sel  <= 1'b1;
                valid_out <= 1'b1;
                dptr      <= dptr + PTR_W'(1);
                pend      <= pend - PEND_W'(1);
            end
        end
    end

    // Sample buffers carry no reset; control state alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (din_valid && !phase_b_c) begin
            abuf[bidx_c] <= din_c;
        end
        if (take_b_c) begin
            dbuf[bidx_c] <= diff_c;
        end
    end

endmodule

// File: tb/tb_fft_step1_bfly_buf.sv
// Directed bench for fft_step1_bfly_buf: reset, ramp, extremes, gapped, back-to-back and idle drain.
module tb_fft_step1_bfly_buf;

    localparam int unsigned IW = 13;
    localparam int unsigned OW = 14;
    localparam int unsigned L  = 16;
    localparam int unsigned D  = 4;
    localparam int unsigned VW = OW * L;

    logic            clk = 1'b0;
    logic            rstn;
    logic            din_valid;
    logic [IW*L-1:0] din_real;
    logic [IW*L-1:0] din_imag;
    logic            valid_out;
    logic            dout_sel;
    logic [OW*L-1:0] dout_real;
    logic [OW*L-1:0] dout_imag;

    fft_step1_bfly_buf #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LANES(L), .DEPTH(D)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_valid (din_valid),
        .din_real  (din_real),
        .din_imag  (din_imag),
        .valid_out (valid_out),
        .dout_sel  (dout_sel),
        .dout_real (dout_real),
        .dout_imag (dout_imag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic          got_sel [$];
    logic [VW-1:0] got_re  [$];
    logic [VW-1:0] got_im  [$];
    int            got_cyc [$];

    logic          exp_sel [$];
    logic [VW-1:0] exp_re  [$];
    logic [VW-1:0] exp_im  [$];
    int            exp_cyc [$];

    int acc_cyc [$];

    // Capture every valid output beat just after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (valid_out === 1'b1) begin
            got_sel.push_back(dout_sel);
            got_re.push_back(dout_real);
            got_im.push_back(dout_imag);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [IW*L-1:0] ivec(input int base, input int step);
        logic [IW*L-1:0] v;
        for (int i = 0; i < L; i++) v[i*IW +: IW] = IW'(base + step * i);
        return v;
    endfunction

    function automatic logic [VW-1:0] ovec(input int base, input int step);
        logic [VW-1:0] v;
        for (int i = 0; i < L; i++) v[i*OW +: OW] = OW'(base + step * i);
        return v;
    endfunction

    task automatic drive_beat(input logic [IW*L-1:0] r, input logic [IW*L-1:0] im);
        @(negedge clk);
        din_valid = 1'b1;
        din_real  = r;
        din_imag  = im;
        acc_cyc.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            din_valid = 1'b0;
        end
    endtask

    // Ramp frame: beat k lane i real = 16k+i, imag = s*(16k+i).
    task automatic send_ramp(input int s, input bit gap);
        for (int k = 0; k < 2 * D; k++) begin
            drive_beat(ivec(16 * k, 1), ivec(s * 16 * k, s));
            if (gap) idle(1);
        end
    endtask

    task automatic send_const(input int a, input int b);
        for (int k = 0; k < 2 * D; k++) begin
            if (k < D) drive_beat(ivec(a, 0), ivec(a, 0));
            else       drive_beat(ivec(b, 0), ivec(b, 0));
        end
    endtask

    // Sums land on the edge accepting each B beat; diffs follow the last B beat back-to-back.
    task automatic expect_ramp(input int s, input int base);
        for (int k = 0; k < D; k++) begin
            exp_sel.push_back(1'b0);
            exp_re.push_back(ovec(32 * k + 64, 2));
            exp_im.push_back(ovec(s * (32 * k + 64), 2 * s));
            exp_cyc.push_back(acc_cyc[base + D + k]);
        end
        for (int k = 0; k < D; k++) begin
            exp_sel.push_back(1'b1);
            exp_re.push_back(ovec(-64, 0));
            exp_im.push_back(ovec(-64 * s, 0));
            exp_cyc.push_back(acc_cyc[base + 2 * D - 1] + 1 + k);
        end
    endtask

    task automatic expect_const(input int sum_v, input int diff_v);
        for (int k = 0; k < 2 * D; k++) begin
            exp_sel.push_back(k >= D);
            exp_re.push_back(ovec(k < D ? sum_v : diff_v, 0));
            exp_im.push_back(ovec(k < D ? sum_v : diff_v, 0));
            exp_cyc.push_back(k < D ? acc_cyc[D + k] : acc_cyc[2 * D - 1] + 1 + (k - D));
        end
    endtask

    task automatic compare(input string tag);
        int n;
        check({tag, "_count"}, VW'(got_sel.size()), VW'(exp_sel.size()));
        n = (got_sel.size() < exp_sel.size()) ? got_sel.size() : exp_sel.size();
        for (int j = 0; j < n; j++) begin
            check($sformatf("%s_sel%0d", tag, j), VW'(got_sel[j]), VW'(exp_sel[j]));
            check($sformatf("%s_re%0d", tag, j), got_re[j], exp_re[j]);
            check($sformatf("%s_im%0d", tag, j), got_im[j], exp_im[j]);
            check($sformatf("%s_cyc%0d", tag, j), VW'(got_cyc[j]), VW'(exp_cyc[j]));
        end
        check({tag, "_idle_valid"}, VW'(valid_out), VW'(0));
        got_sel.delete(); got_re.delete(); got_im.delete(); got_cyc.delete();
        exp_sel.delete(); exp_re.delete(); exp_im.delete(); exp_cyc.delete();
        acc_cyc.delete();
    endtask

    initial begin
        rstn      = 1'b0;
        din_valid = 1'b0;
        din_real  = '0;
        din_imag  = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", VW'(valid_out), VW'(0));
        check("rst_sel", VW'(dout_sel), VW'(0));
        check("rst_re", dout_real, VW'(0));
        check("rst_im", dout_imag, VW'(0));
        rstn = 1'b1;
        idle(2);

        // Partial frame of 5 beats, then async reset mid-frame.
        for (int k = 0; k < 5; k++) drive_beat(ivec(1000, 0), ivec(-1000, 0));
        @(negedge clk);
        din_valid = 1'b0;
        rstn      = 1'b0;
        #1;
        check("midrst_valid", VW'(valid_out), VW'(0));
        check("midrst_sel", VW'(dout_sel), VW'(0));
        check("midrst_re", dout_real, VW'(0));
        check("midrst_im", dout_imag, VW'(0));
        @(negedge clk);
        rstn = 1'b1;
        got_sel.delete(); got_re.delete(); got_im.delete(); got_cyc.delete();
        acc_cyc.delete();
        idle(1);

        // Fresh contiguous ramp after reset, then idle input so the diffs drain.
        send_ramp(0, 1'b0);
        idle(10);
        expect_ramp(0, 0);
        compare("ramp");

        send_const(-4096, -4096);
        idle(10);
        expect_const(-8192, 0);
        compare("ext_neg");

        send_const(4095, -4096);
        idle(10);
        expect_const(-1, 8191);
        compare("ext_mix");

        send_ramp(-1, 1'b1);
        idle(10);
        expect_ramp(-1, 0);
        compare("gapped");

        send_ramp(0, 1'b0);
        send_ramp(-1, 1'b0);
        idle(10);
        expect_ramp(0, 0);
        expect_ramp(-1, 2 * D);
        compare("b2b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
